// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store engine: opcodes, FSM states,
// access sizes and small decode helpers.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Unknown opcodes that still raise memread/memwrite fall back to word accesses.
  function automatic access_size_t decode_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic decode_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_aligned(input access_size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_HALF: return !lane[0];
      SZ_WORD: return lane == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access unit.
// master = the access unit, slave = surrounding pipeline plus data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 11
);
  logic              mem_memread;
  logic              mem_memwrite;
  logic [31:0]       mem_inst;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-3:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;
  logic              mem_stall;
  logic [31:0]       load_data;
  logic              misalign;

  modport master (
    input  mem_memread, mem_memwrite, mem_inst, mem_addr, mem_wdata, dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_stall, load_data, misalign
  );

  modport slave (
    output mem_memread, mem_memwrite, mem_inst, mem_addr, mem_wdata, dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_stall, load_data, misalign
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: builds byte enables and replicated store data, and
// extracts/extends the addressed lane of a read word (little-endian).
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  access_size_t i_size,
  input  logic         i_signed,
  input  logic [1:0]   i_lane,
  input  logic [31:0]  i_wdata,
  input  logic [31:0]  i_rdata,
  output logic [3:0]   o_be,
  output logic [31:0]  o_wdata,
  output logic [31:0]  o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack handshake with variable-latency data
// memory, pipeline stall control and the registered load result.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master bus
);

  logic [1:0]   r_state;
  logic [31:0]  r_load_data;

  access_size_t w_size;
  logic         w_signed;
  logic         w_access;
  logic         w_aligned;
  logic         w_go;
  logic         w_req;
  logic         w_bad_align;
  logic [31:0]  w_load_word;
  logic         w_unused_bits;

  assign w_size      = decode_size(bus.mem_inst[31:26]);
  assign w_signed    = decode_signed(bus.mem_inst[31:26]);
  assign w_access    = bus.mem_memread | bus.mem_memwrite;
  assign w_aligned   = is_aligned(w_size, bus.mem_addr[1:0]);
  assign w_go        = w_access & w_aligned;
  assign w_bad_align = w_access & ~w_aligned;

  // DONE never requests, so a held instruction is not re-issued while the pipeline advances.
  assign w_req = !rst && (((r_state == ST_IDLE) && w_go) || (r_state == ST_BUSY));

  assign bus.dm_req    = w_req;
  assign bus.mem_stall = w_req;
  assign bus.dm_we     = w_req & bus.mem_memwrite;
  assign bus.misalign  = !rst & w_bad_align;
  assign bus.dm_addr   = bus.mem_addr[ADDR_W-1:2];
  assign bus.load_data = r_load_data;

  assign w_unused_bits = ^{bus.mem_inst[25:0], bus.mem_addr[31:ADDR_W]};

  mem_lane_align u_lane_align (
    .i_size   (w_size),
    .i_signed (w_signed),
    .i_lane   (bus.mem_addr[1:0]),
    .i_wdata  (bus.mem_wdata),
    .i_rdata  (bus.dm_rdata),
    .o_be     (bus.dm_be),
    .o_wdata  (bus.dm_wdata),
    .o_rdata  (w_load_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_go) r_state <= bus.dm_ack ? ST_DONE : ST_BUSY;
        ST_BUSY: if (bus.dm_ack) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_data <= '0;
    end else if (w_req && bus.dm_ack && !bus.mem_memwrite) begin
      r_load_data <= w_load_word;
    end else if ((r_state == ST_IDLE) && w_bad_align) begin
      r_load_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, wait states,
// misalignment, reset mid-transaction and back-to-back accesses.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(11)) bus ();

  mem_access_unit #(.ADDR_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rd, input logic wr, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rdata);
    bus.mem_memread  = rd;
    bus.mem_memwrite = wr;
    bus.mem_inst     = {op, 26'h0};
    bus.mem_addr     = addr;
    bus.mem_wdata    = wd;
    bus.dm_ack       = ack;
    bus.dm_rdata     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, OP_LW, 32'h06, 32'h0, 1'b1, 32'h0);
    #3;
    total++; if (bus.dm_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.dm_req); end
    total++; if (bus.mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bus.mem_stall); end
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", bus.misalign); end
    total++; if (bus.load_data !== 32'h0) begin bad++; $display("FAIL rst_load: got %h want 00000000", bus.load_data); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dut.r_state); end
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, OP_LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    sample();
    total++; if (bus.dm_req !== 1'b1) begin bad++; $display("FAIL lw_req: got %b want 1", bus.dm_req); end
    total++; if (bus.mem_stall !== 1'b1) begin bad++; $display("FAIL lw_stall: got %b want 1", bus.mem_stall); end
    total++; if (bus.dm_addr !== 9'h004) begin bad++; $display("FAIL lw_addr: got %h want 004", bus.dm_addr); end
    total++; if (bus.dm_be !== 4'b1111) begin bad++; $display("FAIL lw_be: got %b want 1111", bus.dm_be); end
    total++; if (bus.dm_we !== 1'b0) begin bad++; $display("FAIL lw_we: got %b want 0", bus.dm_we); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.dm_req !== 1'b0 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL lw_done: req=%b stall=%b want 0/0", bus.dm_req, bus.mem_stall); end
    total++; if (dut.r_state !== ST_DONE) begin bad++; $display("FAIL lw_state: got %0d want DONE", dut.r_state); end
    total++; if (bus.load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", bus.load_data); end
    next_cycle();
  endtask

  task automatic test_byte_load(input logic [5:0] op, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, op, 32'h13, 32'h0, 1'b1, 32'h80FF_0000);
    sample();
    total++; if (bus.dm_be !== 4'b1000) begin bad++; $display("FAIL %s_be: got %b want 1000", name, bus.dm_be); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.load_data !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", name, bus.load_data, exp); end
    next_cycle();
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    drive(1'b0, 1'b1, OP_SH, 32'h22, 32'h1234ABCD, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dm_ack = 1'b1;
      sample();
      if (bus.mem_stall === 1'b1) stalls++;
      total++;
      if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1 || bus.dm_addr !== 9'h008 ||
          bus.dm_be !== 4'b1100 || bus.dm_wdata !== 32'hABCDABCD) begin
        bad++;
        $display("FAIL sh_cycle%0d: req=%b we=%b addr=%h be=%b wdata=%h want 1/1/008/1100/abcdabcd",
                 i, bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_be, bus.dm_wdata);
      end
      next_cycle();
    end
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.mem_stall !== 1'b0 || bus.dm_req !== 1'b0) begin bad++; $display("FAIL sh_done: stall=%b req=%b want 0/0", bus.mem_stall, bus.dm_req); end
    total++; if (stalls != 4) begin bad++; $display("FAIL sh_stall_count: got %0d want 4", stalls); end
    total++; if (bus.load_data !== 32'h00000080) begin bad++; $display("FAIL sh_load_hold: got %h want 00000080", bus.load_data); end
    next_cycle();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, OP_LW, 32'h06, 32'h0, 1'b1, 32'hFFFFFFFF);
    sample();
    total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", bus.misalign); end
    total++; if (bus.dm_req !== 1'b0 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL mis_req: req=%b stall=%b want 0/0", bus.dm_req, bus.mem_stall); end
    next_cycle();
    total++; if (bus.load_data !== 32'h0) begin bad++; $display("FAIL mis_data: got %h want 00000000", bus.load_data); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL mis_state: got %0d want IDLE", dut.r_state); end
    drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_store_byte();
    drive(1'b0, 1'b1, OP_SB, 32'h05, 32'h000000A5, 1'b1, 32'h0);
    sample();
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL sb_misalign: got %b want 0", bus.misalign); end
    total++; if (bus.dm_be !== 4'b0010) begin bad++; $display("FAIL sb_be: got %b want 0010", bus.dm_be); end
    total++; if (bus.dm_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bus.dm_wdata); end
    total++; if (bus.dm_addr !== 9'h001 || bus.dm_req !== 1'b1) begin bad++; $display("FAIL sb_addr: addr=%h req=%b want 001/1", bus.dm_addr, bus.dm_req); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.dm_req !== 1'b0 || bus.load_data !== 32'h0) begin bad++; $display("FAIL sb_done: req=%b load=%h want 0/00000000", bus.dm_req, bus.load_data); end
    next_cycle();
  endtask

  task automatic test_half_loads();
    drive(1'b1, 1'b0, OP_LH, 32'h20, 32'h0, 1'b1, 32'h0000_8001);
    sample();
    total++; if (bus.dm_be !== 4'b0011) begin bad++; $display("FAIL lh_be: got %b want 0011", bus.dm_be); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.load_data !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data: got %h want ffff8001", bus.load_data); end
    next_cycle();
    drive(1'b1, 1'b0, OP_LHU, 32'hFFFF_F812, 32'h0, 1'b1, 32'hBEEF_1234);
    sample();
    total++; if (bus.dm_addr !== 9'h004 || bus.dm_be !== 4'b1100) begin bad++; $display("FAIL wrap_addr: addr=%h be=%b want 004/1100", bus.dm_addr, bus.dm_be); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.load_data !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_data: got %h want 0000beef", bus.load_data); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    drive(1'b1, 1'b0, OP_LW, 32'h08, 32'h0, 1'b1, 32'hCAFEF00D);
    sample();
    if (bus.dm_req === 1'b1) reqs++;
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    if (bus.dm_req === 1'b1) reqs++;
    total++; if (bus.dm_req !== 1'b0 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL b2b_gap: req=%b stall=%b want 0/0", bus.dm_req, bus.mem_stall); end
    total++; if (bus.load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_lw_data: got %h want cafef00d", bus.load_data); end
    next_cycle();
    drive(1'b1, 1'b1, OP_SW, 32'h0C, 32'h55AA55AA, 1'b1, 32'h0);
    sample();
    if (bus.dm_req === 1'b1) reqs++;
    total++; if (bus.dm_we !== 1'b1) begin bad++; $display("FAIL b2b_we: got %b want 1", bus.dm_we); end
    total++; if (bus.dm_be !== 4'b1111 || bus.dm_wdata !== 32'h55AA55AA || bus.dm_addr !== 9'h003) begin bad++; $display("FAIL b2b_sw: be=%b wdata=%h addr=%h want 1111/55aa55aa/003", bus.dm_be, bus.dm_wdata, bus.dm_addr); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    if (bus.dm_req === 1'b1) reqs++;
    total++; if (bus.load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_sw_hold: got %h want cafef00d", bus.load_data); end
    next_cycle();
    drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0);
    sample();
    if (bus.dm_req === 1'b1) reqs++;
    total++; if (reqs != 2) begin bad++; $display("FAIL b2b_req_count: got %0d want 2", reqs); end
    next_cycle();
  endtask

  task automatic test_idle_ack();
    drive(1'b0, 1'b0, 6'h00, 32'h10, 32'h0, 1'b1, 32'h12345678);
    sample();
    total++; if (bus.dm_req !== 1'b0 || bus.mem_stall !== 1'b0 || bus.misalign !== 1'b0) begin bad++; $display("FAIL idle_outs: req=%b stall=%b mis=%b want 0/0/0", bus.dm_req, bus.mem_stall, bus.misalign); end
    next_cycle();
    sample();
    total++; if (bus.load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL idle_hold: got %h want cafef00d", bus.load_data); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL idle_state: got %0d want IDLE", dut.r_state); end
    next_cycle();
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 1'b0, OP_LW, 32'h40, 32'h0, 1'b0, 32'h11223344);
    sample();
    next_cycle();
    sample();
    total++; if (dut.r_state !== ST_BUSY || bus.dm_req !== 1'b1) begin bad++; $display("FAIL rb_busy: state=%0d req=%b want BUSY/1", dut.r_state, bus.dm_req); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.dm_req !== 1'b0 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL rb_drop: req=%b stall=%b want 0/0", bus.dm_req, bus.mem_stall); end
    total++; if (dut.r_state !== ST_IDLE || bus.load_data !== 32'h0) begin bad++; $display("FAIL rb_state: state=%0d load=%h want IDLE/00000000", dut.r_state, bus.load_data); end
    next_cycle();
    rst = 1'b0;
    bus.dm_ack = 1'b1;
    sample();
    total++; if (bus.dm_req !== 1'b1 || bus.dm_addr !== 9'h010 || bus.dm_be !== 4'b1111) begin bad++; $display("FAIL rb_reissue: req=%b addr=%h be=%b want 1/010/1111", bus.dm_req, bus.dm_addr, bus.dm_be); end
    next_cycle();
    bus.dm_ack = 1'b0;
    sample();
    total++; if (bus.load_data !== 32'h11223344 || bus.dm_req !== 1'b0) begin bad++; $display("FAIL rb_data: load=%h req=%b want 11223344/0", bus.load_data, bus.dm_req); end
    next_cycle();
    drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_load(OP_LB, 32'hFFFFFF80, "lb");
    test_byte_load(OP_LBU, 32'h00000080, "lbu");
    test_store_wait();
    test_misalign();
    test_store_byte();
    test_half_loads();
    test_back_to_back();
    test_idle_ack();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
